// File: rtl/pipelined_barrel_shifter.sv
// -----------------------------------------------------------------------------
// pipelined_barrel_shifter
//
// LAT-stage (LAT = log2(WIDTH)) barrel shifter with valid/ready handshakes on
// both sides. Stage s applies a shift of 2^s when shamt bit s is set, so a
// result leaves LAT cycles after its operand was accepted, plus any stall.
// The whole pipeline advances together, so bubbles are kept, never squeezed.
//
// Ports:
//   clk_i    - clock, rising edge
//   rst_ni   - asynchronous active-low reset, clears every stage
//   valid_i  - input transaction offered
//   ready_o  - block can accept an input this cycle (= pipeline advance)
//   data_i   - operand, WIDTH bits
//   shamt_i  - shift amount, LAT bits
//   dir_i    - 0 = right, 1 = left
//   mode_i   - 00 rotate, 01 logical, 10 arithmetic, 11 bit-reverse
//   valid_o  - result presented
//   ready_i  - downstream accepts the result
//   data_o   - result, WIDTH bits
//   zero_o   - result is valid and all zeros
// -----------------------------------------------------------------------------
module pipelined_barrel_shifter #(
    parameter int WIDTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  logic [WIDTH-1:0]           data_i,
    input  logic [$clog2(WIDTH)-1:0]   shamt_i,
    input  logic                       dir_i,
    input  logic [1:0]                 mode_i,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       zero_o
);

    localparam int LAT = $clog2(WIDTH);

    typedef enum logic [1:0] {
        MODE_ROT = 2'b00,
        MODE_LSH = 2'b01,
        MODE_ASH = 2'b10,
        MODE_REV = 2'b11
    } mode_e;

    // Control carried alongside each data word. sign is the MSB of the
    // original operand, so arithmetic right fills stay correct even after
    // earlier stages have already shifted the word.
    typedef struct packed {
        logic [LAT-1:0] shamt;
        logic           dir;
        mode_e          mode;
        logic           sign;
    } ctl_t;

    // One stage's fixed shift by k bit positions.
    function automatic logic [WIDTH-1:0] shift_stage(
        input logic [WIDTH-1:0] d,
        input int               k,
        input logic             dir,
        input mode_e            mode,
        input logic             sign
    );
        logic [WIDTH-1:0] r;
        logic [LAT-1:0]   idx;
        logic             vacated;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (dir) begin
                idx     = LAT'((i - k + WIDTH) % WIDTH);
                vacated = (i < k);
            end else begin
                idx     = LAT'((i + k) % WIDTH);
                vacated = (i + k >= WIDTH);
            end
            if (!vacated || mode == MODE_ROT) begin
                r[i] = d[idx];
            end else if (mode == MODE_ASH && !dir) begin
                r[i] = sign;
            end else begin
                r[i] = 1'b0;
            end
        end
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] bit_reverse(input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = d[WIDTH-1-i];
        end
        return r;
    endfunction

    // Stage registers. Control is only needed by stages that feed another.
    logic             vld_q [LAT];
    logic [WIDTH-1:0] dat_q [LAT];
    ctl_t             ctl_q [LAT-1];

    // Per-stage inputs and the shifted word each stage will capture.
    logic             in_vld [LAT];
    logic [WIDTH-1:0] in_dat [LAT];
    ctl_t             in_ctl [LAT];
    logic [WIDTH-1:0] nxt_dat[LAT];

    logic adv;

    assign valid_o = vld_q[LAT-1];
    assign data_o  = dat_q[LAT-1];
    assign zero_o  = vld_q[LAT-1] && (dat_q[LAT-1] == '0);
    assign adv     = !valid_o || ready_i;
    assign ready_o = adv;

    always_comb begin
        // Bit reversal is done entirely as stage 0 loads; later stages pass
        // reverse-mode words through so the latency is still LAT.
        in_vld[0] = valid_i;
        in_dat[0] = (mode_e'(mode_i) == MODE_REV) ? bit_reverse(data_i) : data_i;
        in_ctl[0] = '{shamt: shamt_i, dir: dir_i, mode: mode_e'(mode_i),
                      sign: data_i[WIDTH-1]};
        for (int s = 1; s < LAT; s++) begin
            in_vld[s] = vld_q[s-1];
            in_dat[s] = dat_q[s-1];
            in_ctl[s] = ctl_q[s-1];
        end
        for (int s = 0; s < LAT; s++) begin
            if (in_ctl[s].shamt[s] && in_ctl[s].mode != MODE_REV) begin
                nxt_dat[s] = shift_stage(in_dat[s], 1 << s, in_ctl[s].dir,
                                         in_ctl[s].mode, in_ctl[s].sign);
            end else begin
                nxt_dat[s] = in_dat[s];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its predecessor's value from before this edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: the data words are reset too, not just the valid bits,
            // because data_o must read zero while reset is held.
            for (int s = 0; s < LAT; s++) begin
                vld_q[s] <= 1'b0;
                dat_q[s] <= '0;
            end
            for (int s = 0; s < LAT - 1; s++) begin
                ctl_q[s] <= '0;
            end
        end else if (adv) begin
            for (int s = 0; s < LAT; s++) begin
                vld_q[s] <= in_vld[s];
                // Words only move with a valid transaction, so data_o keeps
                // its last value while bubbles pass through.
                if (in_vld[s]) begin
                    dat_q[s] <= nxt_dat[s];
                end
            end
            for (int s = 0; s < LAT - 1; s++) begin
                if (in_vld[s]) begin
                    ctl_q[s] <= in_ctl[s];
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// -----------------------------------------------------------------------------
// tb_pipelined_barrel_shifter
//
// Self-checking bench for pipelined_barrel_shifter at WIDTH=8 (LAT=3).
// Expected results are queued when an input transfer happens and compared
// when an output transfer happens, together with the transfer latency.
// -----------------------------------------------------------------------------
module tb_pipelined_barrel_shifter;

    localparam int WIDTH = 8;
    localparam int LAT   = 3;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             valid_i;
    logic             ready_o;
    logic [WIDTH-1:0] data_i;
    logic [LAT-1:0]   shamt_i;
    logic             dir_i;
    logic [1:0]       mode_i;
    logic             valid_o;
    logic             ready_i;
    logic [WIDTH-1:0] data_o;
    logic             zero_o;

    pipelined_barrel_shifter #(.WIDTH(WIDTH)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (data_i),
        .shamt_i (shamt_i),
        .dir_i   (dir_i),
        .mode_i  (mode_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o),
        .zero_o  (zero_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [7:0] data;
        logic [2:0] shamt;
        logic       dir;
        logic [1:0] mode;
        logic [7:0] exp;
    } vec_t;

    typedef struct {
        logic [7:0] exp;
        int         acc_cycle;
        int         acc_stalls;
    } sb_t;

    sb_t        sb[$];
    logic [7:0] cur_exp;
    int         n_tests = 0;
    int         n_fail  = 0;
    int         cycle   = 0;
    int         stalls  = 0;
    bit         done;
    vec_t       tbl [19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Independent reference: word-level operators rather than per-stage shifts.
    function automatic logic [7:0] ref_model(input logic [7:0] d, input logic [2:0] sh,
                                             input logic dir, input logic [1:0] mode);
        logic [15:0] dd;
        case (mode)
            2'b00: begin
                if (dir) begin
                    dd = {d, d} << sh;
                    return dd[15:8];
                end else begin
                    dd = {d, d} >> sh;
                    return dd[7:0];
                end
            end
            2'b01:   return dir ? (d << sh) : (d >> sh);
            2'b10:   return dir ? (d << sh) : 8'($signed(d) >>> sh);
            default: return {<<{d}};
        endcase
    endfunction

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk_i) begin
        sb_t e;
        if (rst_ni) begin
            if (valid_o && ready_i) begin
                if (sb.size() == 0) begin
                    check("unexpected valid_o", valid_o, 1'b0);
                end else begin
                    e = sb.pop_front();
                    check("data_o", data_o, e.exp);
                    check("zero_o", zero_o, e.exp == 8'h00);
                    check("latency", cycle - e.acc_cycle, LAT + stalls - e.acc_stalls);
                end
            end
            if (valid_o && !ready_i) stalls++;
            if (valid_i && ready_o) sb.push_back('{cur_exp, cycle, stalls});
        end
        cycle++;
    end

    // Offer one transaction; returns #1 after the edge that captured it.
    task automatic send(input logic [7:0] d, input logic [2:0] sh, input logic dir,
                        input logic [1:0] mode, input logic [7:0] exp);
        bit acc;
        int n;
        n       = 0;
        valid_i = 1'b1;
        data_i  = d;
        shamt_i = sh;
        dir_i   = dir;
        mode_i  = mode;
        cur_exp = exp;
        do begin
            @(negedge clk_i);
            acc = ready_o;
            @(posedge clk_i);
            #1;
            n++;
        end while (!acc && n < 200);
        check("send accepted", acc, 1'b1);
        valid_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        check("drain empty", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] held;
        tbl[0]  = '{8'hB1, 3'd3, 1'b0, 2'b00, 8'h36};
        tbl[1]  = '{8'hB1, 3'd3, 1'b1, 2'b00, 8'h8D};
        tbl[2]  = '{8'h90, 3'd2, 1'b0, 2'b10, 8'hE4};
        tbl[3]  = '{8'h90, 3'd2, 1'b0, 2'b01, 8'h24};
        tbl[4]  = '{8'h81, 3'd1, 1'b1, 2'b01, 8'h02};
        tbl[5]  = '{8'h80, 3'd0, 1'b1, 2'b01, 8'h80};
        tbl[6]  = '{8'h80, 3'd0, 1'b0, 2'b11, 8'h01};
        tbl[7]  = '{8'h01, 3'd7, 1'b0, 2'b01, 8'h00};
        tbl[8]  = '{8'h80, 3'd7, 1'b0, 2'b10, 8'hFF};
        tbl[9]  = '{8'h7F, 3'd3, 1'b0, 2'b10, 8'h0F};
        tbl[10] = '{8'h96, 3'd4, 1'b1, 2'b10, 8'h60};
        tbl[11] = '{8'hA5, 3'd0, 1'b0, 2'b00, 8'hA5};
        tbl[12] = '{8'h0F, 3'd5, 1'b1, 2'b11, 8'hF0};
        tbl[13] = '{8'h35, 3'd6, 1'b0, 2'b11, 8'hAC};
        tbl[14] = '{8'h01, 3'd7, 1'b1, 2'b00, 8'h80};
        tbl[15] = '{8'hC3, 3'd4, 1'b0, 2'b00, 8'h3C};
        tbl[16] = '{8'h00, 3'd3, 1'b1, 2'b00, 8'h00};
        tbl[17] = '{8'hB4, 3'd0, 1'b0, 2'b10, 8'hB4};
        tbl[18] = '{8'hB1, 3'd5, 1'b0, 2'b00, 8'h8D};

        rst_ni  = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b1;
        data_i  = '0;
        shamt_i = '0;
        dir_i   = 1'b0;
        mode_i  = '0;
        cur_exp = '0;
        done    = 1'b0;

        // Reset state, and no capture while reset is held.
        #1 rst_ni = 1'b0;
        #1;
        check("reset valid_o", valid_o, 1'b0);
        check("reset data_o", data_o, 8'h00);
        check("reset zero_o", zero_o, 1'b0);
        check("reset ready_o", ready_o, 1'b1);
        valid_i = 1'b1;
        data_i  = 8'hFF;
        repeat (2) @(posedge clk_i);
        #1;
        check("held reset data_o", data_o, 8'h00);
        valid_i = 1'b0;
        rst_ni  = 1'b1;
        for (int i = 0; i < LAT + 1; i++) begin
            @(negedge clk_i);
            check("no capture during reset", valid_o, 1'b0);
        end
        @(posedge clk_i);
        #1;

        // Directed vectors, back to back with ready_i=1.
        for (int i = 0; i < 19; i++) begin
            send(tbl[i].data, tbl[i].shamt, tbl[i].dir, tbl[i].mode, tbl[i].exp);
        end
        drain();

        // Backpressure: 6 inputs, ready_i low for 4 cycles once valid_o rises.
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    logic [7:0] d;
                    logic [2:0] sh;
                    logic [1:0] md;
                    d  = 8'(8'h1D * (i + 1));
                    sh = 3'(i + 1);
                    md = 2'(i % 3);
                    send(d, sh, i[0], md, ref_model(d, sh, i[0], md));
                end
            end
            begin
                int n;
                n = 0;
                do begin
                    @(negedge clk_i);
                    n++;
                end while (!valid_o && n < 50);
                check("valid_o rises", valid_o, 1'b1);
                @(posedge clk_i);
                #1;
                ready_i = 1'b0;
                held    = data_o;
                repeat (4) begin
                    @(negedge clk_i);
                    check("stall ready_o", ready_o, 1'b0);
                    check("stall valid_o", valid_o, 1'b1);
                    check("stall data_o held", data_o, held);
                end
                @(posedge clk_i);
                #1;
                ready_i = 1'b1;
            end
        join
        drain();

        // Reset mid-flight: two inputs, reset while the second is presented.
        send(8'hB1, 3'd3, 1'b0, 2'b00, 8'h36);
        send(8'h81, 3'd1, 1'b1, 2'b01, 8'h02);
        begin
            int n;
            n = 0;
            do begin
                @(negedge clk_i);
                n++;
            end while (!valid_o && n < 20);
        end
        @(posedge clk_i);
        #1;
        check("pre-reset valid_o", valid_o, 1'b1);
        rst_ni = 1'b0;
        #1;
        check("async reset valid_o", valid_o, 1'b0);
        check("async reset data_o", data_o, 8'h00);
        check("async reset zero_o", zero_o, 1'b0);
        check("async reset ready_o", ready_o, 1'b1);
        sb.delete();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check("no stale result", valid_o, 1'b0);
        end
        @(posedge clk_i);
        #1;
        send(8'h90, 3'd2, 1'b0, 2'b10, 8'hE4);
        drain();

        // Random stream against the reference model with random backpressure.
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    logic [7:0] d;
                    logic [2:0] sh;
                    logic       dr;
                    logic [1:0] md;
                    d  = 8'($urandom);
                    sh = 3'($urandom_range(0, 7));
                    dr = 1'($urandom_range(0, 1));
                    md = 2'($urandom_range(0, 3));
                    send(d, sh, dr, md, ref_model(d, sh, dr, md));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk_i);
                    #1;
                    ready_i = ($urandom_range(0, 3) != 0);
                end
            end
        join
        ready_i = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
